csr_regfile: RTL
================

Name: csr_regfile

Overview:
- Parametrised machine-mode CSR unit for the RV32 core. It is the successor to the combinational CSR ALU.
- Performs CSRRW/CSRRS/CSRRC (register and immediate forms) read-modify-write on real state.
- Holds trap state and handles trap entry and MRET.
- Runs the mcycle/minstret counters and produces the interrupt-take request.
- Sits in EX: read data returns combinationally the same cycle; all state updates commit at the next clock edge.

Parameters:
- XLEN, 32, data width; 32 or 64. Counters are always 64 bits; the high halves are visible only when XLEN=32.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- HAS_COUNTERS, 1, 0 removes mcycle/minstret: reads return 0, writes are ignored.
- MHARTID, 0, value returned by mhartid.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- csr_valid  in  1  CSR instruction in EX this cycle
- csr_op  in  2  01=RW, 10=RS, 11=RC, 00=none
- csr_addr  in  12  CSR address
- csr_src  in  XLEN  rs1 data or zero-extended zimm
- csr_src_zero  in  1  rs1==x0 or zimm==0; suppresses the write for RS/RC
- csr_rdata  out  XLEN  old CSR value, for rd
- csr_illegal  out  1  illegal CSR access this cycle
- trap_valid  in  1  take trap this cycle
- trap_cause  in  XLEN  mcause value; bit XLEN-1 set means interrupt
- trap_pc  in  XLEN  faulting or interrupted PC
- trap_tval  in  XLEN  mtval value
- mret_valid  in  1  MRET retiring
- instret_inc  in  1  one instruction retired
- irq_ext / irq_timer / irq_soft  in  1 each  level interrupt lines
- trap_vector  out  XLEN  target PC for the current trap
- mepc_out  out  XLEN  current mepc, used as the MRET target
- irq_take  out  1  an enabled interrupt is pending

Behaviour:
- Reset (async, rst_n=0) values:
  - mstatus: MIE=0, MPIE=0; MPP reads 2'b11.
  - mie, mepc, mcause, mtval, mscratch = 0; mtvec = MTVEC_RESET; counters = 0.
  - All outputs are derived from these values; irq_take=0.
- Implemented CSRs:
  - mstatus 0x300 (only bits 3, 7, 12:11 exist; others read 0)
  - misa 0x301 (read-only constant, RV32I/RV64I)
  - mie 0x304 (bits 3, 7, 11 writable)
  - mtvec 0x305, mscratch 0x340
  - mepc 0x341 (bits 1:0 forced to 0)
  - mcause 0x342, mtval 0x343
  - mip 0x344 (read-only mirror: bit 3=irq_soft, 7=irq_timer, 11=irq_ext; writes ignored)
  - mcycle 0xB00, minstret 0xB02; mcycleh 0xB80 and minstreth 0xB82 only when XLEN=32
  - mhartid 0xF14
- Read path: csr_rdata is combinational, equal to the current register value; 0 when illegal or when csr_valid=0.
- Write value:
  - RW: csr_src
  - RS: old | csr_src
  - RC: old & ~csr_src
- Write enable: csr_valid & (op==RW | ~csr_src_zero) & ~csr_illegal. The value commits at the next posedge.
- csr_illegal is asserted (combinational) for:
  - csr_valid with an unimplemented address;
  - csr_valid with csr_op=00;
  - a write-enabled access to addr[11:10]==2'b11.
  - mip is in the writable range; writes to it are silently dropped, not flagged illegal.
  - csr_illegal never changes any state.
- Same-cycle priority: trap_valid > mret_valid > CSR write. A CSR write in the same cycle as trap or MRET is dropped.
- Trap entry (posedge with trap_valid):
  - MPIE<=MIE, MIE<=0
  - mepc<=trap_pc with bits 1:0 cleared
  - mcause<=trap_cause, mtval<=trap_tval
- MRET: MIE<=MPIE, MPIE<=1.
- trap_vector (combinational):
  - base = {mtvec[XLEN-1:2],2'b00}.
  - If mtvec[1:0]==01 and trap_cause[XLEN-1]=1, trap_vector = base + 4*trap_cause[5:0]; otherwise base.
  - mtvec[1:0] values 10 and 11 are written as 00.
- irq_take = MIE & |(mip & mie) (combinational).
- Counters:
  - mcycle increments by 1 every cycle and wraps from 2^64-1 to 0.
  - minstret increments when instret_inc=1.
  - A CSR write to any half overrides that counter's increment in that cycle; the written half takes the written value, and the other half holds.
  - Carry from the low half to the high half is part of the single 64-bit increment.
- Reset asserted mid-instruction: state returns to reset values immediately; any pending write is lost.

Test Plan:
- Reset, then csrrw mscratch with src=0xDEADBEEF -> rdata=0 that cycle; next read returns 0xDEADBEEF.
- Set mscratch=0xF0F0_00FF; csrrs with src=0x0F00 -> rdata 0xF0F0_00FF, new value 0xF0F0_0FFF. Then csrrc with src=0x00FF -> new value 0xF0F0_0F00. csrrs with csr_src_zero=1 -> no write.
- Write mcycle low half = 0xFFFF_FFFE (XLEN=32); 3 cycles later mcycleh=1 and mcycle=1. Write to mcycle in the same cycle as the increment -> the written value wins.
- Write mstatus=0x8 and mtvec=0x1001; trap with cause 0x8000_0007 and pc 0x1236 -> trap_vector=0x101C; next cycle mepc=0x1234, MIE=0, MPIE=1. Then mret -> MIE=1.
- Write mie=0x80 with MIE=1; raise irq_timer -> irq_take=1 the same cycle. Lower it, or clear MIE -> irq_take=0.
- csrrw to mhartid, or to address 0x7C0 -> csr_illegal=1 and no state change. Trap and csrrw mscratch in the same cycle -> mscratch unchanged.

Source files
------------

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: CSRRW/RS/RC read-modify-write, trap entry/MRET, mcycle/minstret, interrupt-take.
// Latency: read data and illegal flag are combinational in EX; all state commits at the next clk edge.
// Backpressure: none; every access completes in its cycle, and a trap or MRET in the same cycle drops the CSR write.
module csr_regfile #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
    parameter int              HAS_COUNTERS = 1,
    parameter logic [XLEN-1:0] MHARTID      = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_src,
    input  logic            csr_src_zero,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    input  logic            instret_inc,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_soft,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_out,
    output logic            irq_take
);

    localparam logic [1:0]      OP_RW    = 2'b01;
    localparam logic [1:0]      OP_RS    = 2'b10;
    localparam logic [1:0]      OP_RC    = 2'b11;
    localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(12'h888);

    logic            r_mstatus_mie, r_mstatus_mpie;
    logic [XLEN-1:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [63:0]     r_mcycle, r_minstret;

    logic [XLEN-1:0] w_mstatus, w_mip, w_misa, w_csr_val, w_wdata, w_base;
    logic [63:0]     w_mcycle, w_minstret;
    logic            w_hit, w_we_req, w_we;

    // Replace the low half (whole counter when XLEN=64) with the written value
    function automatic logic [63:0] f_wr_lo(input logic [63:0] cnt, input logic [XLEN-1:0] d);
        return (XLEN == 32) ? {cnt[63:32], d[31:0]} : 64'(d);
    endfunction

    // Replace only the high half; used by mcycleh/minstreth
    function automatic logic [63:0] f_wr_hi(input logic [63:0] cnt, input logic [XLEN-1:0] d);
        return {d[31:0], cnt[31:0]};
    endfunction

    assign w_mstatus  = XLEN'({2'b11, 3'b000, r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000});
    assign w_mip      = XLEN'({irq_ext, 3'b000, irq_timer, 3'b000, irq_soft, 3'b000});
    assign w_mcycle   = (HAS_COUNTERS != 0) ? r_mcycle   : 64'd0;
    assign w_minstret = (HAS_COUNTERS != 0) ? r_minstret : 64'd0;

    // misa: MXL field plus the I extension bit
    always_comb begin
        w_misa = '0;
        w_misa[XLEN-1:XLEN-2] = (XLEN == 32) ? 2'b01 : 2'b10;
        w_misa[8] = 1'b1;
    end

    // Address decode and current value of the addressed CSR
    always_comb begin
        w_hit     = 1'b1;
        w_csr_val = '0;
        case (csr_addr)
            12'h300: w_csr_val = w_mstatus;
            12'h301: w_csr_val = w_misa;
            12'h304: w_csr_val = r_mie;
            12'h305: w_csr_val = r_mtvec;
            12'h340: w_csr_val = r_mscratch;
            12'h341: w_csr_val = r_mepc;
            12'h342: w_csr_val = r_mcause;
            12'h343: w_csr_val = r_mtval;
            12'h344: w_csr_val = w_mip;
            12'hB00: w_csr_val = XLEN'(w_mcycle);
            12'hB02: w_csr_val = XLEN'(w_minstret);
            12'hB80: if (XLEN == 32) w_csr_val = XLEN'(w_mcycle[63:32]);   else w_hit = 1'b0;
            12'hB82: if (XLEN == 32) w_csr_val = XLEN'(w_minstret[63:32]); else w_hit = 1'b0;
            12'hF14: w_csr_val = MHARTID;
            default: w_hit = 1'b0;
        endcase
    end

    // Read-modify-write value from the old CSR contents
    always_comb begin
        case (csr_op)
            OP_RS:   w_wdata = w_csr_val | csr_src;
            OP_RC:   w_wdata = w_csr_val & ~csr_src;
            default: w_wdata = csr_src;
        endcase
    end

    // Legality; the write request does not depend on legality, so no loop
    assign w_we_req    = csr_valid & ((csr_op == OP_RW) | ~csr_src_zero);
    assign csr_illegal = csr_valid & ((csr_op == 2'b00) | ~w_hit |
                                      (w_we_req & (csr_addr[11:10] == 2'b11)));
    assign w_we        = w_we_req & ~csr_illegal & ~trap_valid & ~mret_valid;
    assign csr_rdata   = (csr_valid & ~csr_illegal) ? w_csr_val : '0;

    assign w_base      = {r_mtvec[XLEN-1:2], 2'b00};
    assign trap_vector = ((r_mtvec[1:0] == 2'b01) && trap_cause[XLEN-1])
                         ? w_base + XLEN'({trap_cause[5:0], 2'b00}) : w_base;
    assign mepc_out    = r_mepc;
    assign irq_take    = r_mstatus_mie & |(w_mip & r_mie);

    // Trap state and CSR writes; trap beats MRET beats a CSR write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RESET;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
        end else if (trap_valid) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
            r_mepc         <= {trap_pc[XLEN-1:2], 2'b00};
            r_mcause       <= trap_cause;
            r_mtval        <= trap_tval;
        end else if (mret_valid) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_we) begin
            case (csr_addr)
                12'h300: begin
                    r_mstatus_mie  <= w_wdata[3];
                    r_mstatus_mpie <= w_wdata[7];
                end
                12'h304: r_mie      <= w_wdata & IRQ_MASK;
                12'h305: r_mtvec    <= {w_wdata[XLEN-1:2], (w_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
                12'h340: r_mscratch <= w_wdata;
                12'h341: r_mepc     <= {w_wdata[XLEN-1:2], 2'b00};
                12'h342: r_mcause   <= w_wdata;
                12'h343: r_mtval    <= w_wdata;
                default: ;
            endcase
        end
    end

    // 64-bit counters; a write to either half replaces that cycle's increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else if (HAS_COUNTERS != 0) begin
            if (w_we && csr_addr == 12'hB00)
                r_mcycle <= f_wr_lo(r_mcycle, w_wdata);
            else if (w_we && csr_addr == 12'hB80 && XLEN == 32)
                r_mcycle <= f_wr_hi(r_mcycle, w_wdata);
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (w_we && csr_addr == 12'hB02)
                r_minstret <= f_wr_lo(r_minstret, w_wdata);
            else if (w_we && csr_addr == 12'hB82 && XLEN == 32)
                r_minstret <= f_wr_hi(r_minstret, w_wdata);
            else if (instret_inc)
                r_minstret <= r_minstret + 64'd1;
        end
    end

endmodule
